// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: shared FSM state type and command-frame layout for spi_regfile_slave
package spi_regfile_pkg;
  typedef enum logic [2:0] {IDLE, CMD, RD_DATA, WR_DATA, HOLD} state_e;
  localparam int CMD_W = 8;
  localparam int CMD_RD_BIT = 7;
  localparam int CMD_ADDR_MSB = 6;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronises sclk/mosi/cs_n into clk and flags sclk rise/fall and cs_n fall
// Ports: clk, rst_n (async active-low); sclk_i/mosi_i/cs_n_i async pins;
//   mosi_o/cs_n_o synchronised levels; sclk_rise_o/sclk_fall_o/cs_fall_o single-cycle pulses.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_i,
  input  logic mosi_i,
  input  logic cs_n_i,
  output logic mosi_o,
  output logic cs_n_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_fall_o
);
  logic [SYNC_STAGES-1:0] sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d;
  logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  always_comb begin
    sclk_d = {sclk_q[SYNC_STAGES-2:0], sclk_i};
    mosi_d = {mosi_q[SYNC_STAGES-2:0], mosi_i};
    cs_d = {cs_q[SYNC_STAGES-2:0], cs_n_i};
    sclk_prev_d = sclk_q[SYNC_STAGES-1];
    cs_prev_d = cs_q[SYNC_STAGES-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      mosi_q <= '0;
      cs_q <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q <= 1'b1;
    end else begin
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      cs_q <= cs_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q <= cs_prev_d;
    end
  end
  assign mosi_o = mosi_q[SYNC_STAGES-1];
  assign cs_n_o = cs_q[SYNC_STAGES-1];
  assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
  assign cs_fall_o = ~cs_q[SYNC_STAGES-1] & cs_prev_q;
endmodule

// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave: SPI mode-1 slave giving a master read/write access to a register file
// Ports: clk, rst_n (async active-low); sclk_i/mosi_i/cs_n_i async SPI pins;
//   miso_o/miso_oe_o data out and enable; regs_o flat register contents;
//   wr_strobe_o/wr_addr_o committed-write pulse and address; busy_o frame in progress.
// Build option SPI_BURST_EN: address auto-increments per data word within one frame.
module spi_regfile_slave
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = {24'h030201, 8'h96},
  parameter int SYNC_STAGES = 2,
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk_i,
  input  logic                       mosi_i,
  input  logic                       cs_n_i,
  output logic                       miso_o,
  output logic                       miso_oe_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_strobe_o,
  output logic [AW-1:0]              wr_addr_o,
  output logic                       busy_o
);
  logic mosi_s, cs_n_s, rise, fall, cs_fall;
  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [CMD_W-2:0] cmd_q, cmd_d;
  logic [DATA_W-1:0] wsh_q, wsh_d, shadow_q, shadow_d, wr_word;
  logic [CMD_ADDR_MSB:0] addr_q, addr_d, addr_inc, ld_addr;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, ld_idx;
  logic miso_q, miso_d, wr_strobe_q, wr_strobe_d, ld;
  logic [CMD_W-1:0] cmd_full;
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk_i), .mosi_i(mosi_i), .cs_n_i(cs_n_i),
    .mosi_o(mosi_s), .cs_n_o(cs_n_s), .sclk_rise_o(rise), .sclk_fall_o(fall), .cs_fall_o(cs_fall)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cmd_d = cmd_q;
    wsh_d = wsh_q;
    shadow_d = shadow_q;
    addr_d = addr_q;
    miso_d = miso_q;
    regs_d = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d = wr_addr_q;
    ld = 1'b0;
    ld_addr = addr_q;
    cmd_full = {cmd_q, mosi_s};
    wr_word = DATA_W'({wsh_q, mosi_s});
    addr_inc = (32'(addr_q) == NUM_REGS - 1) ? '0 : addr_q + 1'b1;
    if (cs_n_s) begin
      state_d = IDLE;
      cnt_d = '0;
      miso_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = cs_fall ? CMD : IDLE;
        CMD: if (fall) begin
          cmd_d = cmd_full[CMD_W-2:0];
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(CMD_W - 1)) begin
            cnt_d = '0;
            addr_d = cmd_full[CMD_ADDR_MSB:0];
            state_d = cmd_full[CMD_RD_BIT] ? RD_DATA : WR_DATA;
            ld = cmd_full[CMD_RD_BIT];
            ld_addr = cmd_full[CMD_ADDR_MSB:0];
          end
        end
        RD_DATA: if (rise) begin
          miso_d = shadow_q[DATA_W-1];
          shadow_d = shadow_q << 1;
        end else if (fall) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(DATA_W - 1)) begin
            cnt_d = '0;
`ifdef SPI_BURST_EN
            addr_d = addr_inc;
            ld = 1'b1;
            ld_addr = addr_inc;
`else
            state_d = HOLD;
            miso_d = 1'b0;
`endif
          end
        end
        WR_DATA: if (fall) begin
          wsh_d = wr_word;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(DATA_W - 1)) begin
            cnt_d = '0;
            if (32'(addr_q) < NUM_REGS) begin
              regs_d[int'(AW'(addr_q)) * DATA_W +: DATA_W] = wr_word;
              wr_strobe_d = 1'b1;
              wr_addr_d = AW'(addr_q);
            end
`ifdef SPI_BURST_EN
            addr_d = addr_inc;
`else
            state_d = HOLD;
`endif
          end
        end
        HOLD: state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
    ld_idx = AW'(ld_addr);
    if (ld) shadow_d = (32'(ld_addr) < NUM_REGS) ? regs_q[int'(ld_idx) * DATA_W +: DATA_W] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cmd_q <= '0;
      wsh_q <= '0;
      shadow_q <= '0;
      addr_q <= '0;
      miso_q <= 1'b0;
      regs_q <= RESET_VALS;
      wr_strobe_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
      wsh_q <= wsh_d;
      shadow_q <= shadow_d;
      addr_q <= addr_d;
      miso_q <= miso_d;
      regs_q <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q <= wr_addr_d;
    end
  end
  assign miso_o = miso_q;
  assign miso_oe_o = ~cs_n_s;
  assign regs_o = regs_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o = wr_addr_q;
  assign busy_o = state_q != IDLE;
endmodule
